snake_dir_input: RTL and testbench

- Multi-player direction input conditioner for the snake game. Sits between the raw `ui_in` button pins and the game core.
- Per button: synchronises, debounces and edge-detects the input.
- Per player: rejects illegal turns (repeat and 180° reversal) and buffers accepted turns in a small queue.
- Releases one queued turn per game step, so fast button sequences between steps are not lost.

---
 rtl/snake_dir_input.sv | 217 +++++++++++++++++++++
 tb/tb_snake_dir_input.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/snake_dir_input.sv
// snake_dir_input: direction input conditioner for the snake game.
// Each raw button is synchronised, optionally debounced and edge-detected.
// Each player then gets one press per cycle after up > down > left > right
// priority. Repeats and reversals of the newest queued direction (or of the
// current direction when the queue is empty) are rejected. Accepted turns are
// buffered in a small queue that releases one entry per game tick.
//
// Build option:
//   SNAKE_DEBOUNCE_EN  defined   -> counter debouncer, 2^DEBOUNCE_W stable cycles
//                      undefined -> debouncer bypassed, presses lag pins by 3 cycles
//
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   i_btn       raw buttons, player p = [4p+3:4p] = {right, left, down, up}
//   i_tick      game-step strobe, pops one queued direction per player
//   i_restart   synchronous restart: empties queues, reloads directions
//   o_dir       current direction per player (00 up, 01 down, 10 left, 11 right)
//   o_pressed   one-cycle pulse per player when a turn is queued
//   o_overflow  one-cycle pulse per player when a legal turn is dropped (queue full)
module snake_dir_input #(
    parameter int unsigned PLAYERS     = 1,
    parameter int unsigned DEBOUNCE_W  = 16,
    parameter int unsigned QUEUE_DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [4*PLAYERS-1:0]   i_btn,
    input  logic                   i_tick,
    input  logic                   i_restart,
    output logic [2*PLAYERS-1:0]   o_dir,
    output logic [PLAYERS-1:0]     o_pressed,
    output logic [PLAYERS-1:0]     o_overflow
);

    localparam int unsigned NB    = 4 * PLAYERS;
    localparam int unsigned PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH + 1);

    // Elaboration-time parameter range checks
    if (PLAYERS < 1 || PLAYERS > 4) begin : g_bad_players
        $error("snake_dir_input: PLAYERS must be 1..4");
    end
    if (QUEUE_DEPTH < 1 || QUEUE_DEPTH > 4) begin : g_bad_depth
        $error("snake_dir_input: QUEUE_DEPTH must be 1..4");
    end
    if (DEBOUNCE_W < 1) begin : g_bad_debounce
        $error("snake_dir_input: DEBOUNCE_W must be at least 1");
    end

    // Circular pointer increment, wraps modulo QUEUE_DEPTH
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        if (ptr == PTR_W'(QUEUE_DEPTH - 1)) begin
            return '0;
        end
        return ptr + PTR_W'(1);
    endfunction

    logic [NB-1:0] sync1_q;
    logic [NB-1:0] sync2_q;
    logic [NB-1:0] deb;
    logic [NB-1:0] deb_prev_q;
    logic [NB-1:0] press;

    // Two-flop synchroniser and previous-level register for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            deb_prev_q <= '0;
        end else begin
            sync1_q    <= i_btn;
            sync2_q    <= sync1_q;
            deb_prev_q <= deb;
        end
    end

`ifdef SNAKE_DEBOUNCE_EN
    // Per-button debouncer: level follows sync after 2^DEBOUNCE_W differing cycles
    for (genvar b = 0; b < NB; b++) begin : g_deb
        logic [DEBOUNCE_W-1:0] cnt_q;
        logic                  deb_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q <= '0;
                deb_q <= 1'b0;
            end else if (sync2_q[b] == deb_q) begin
                cnt_q <= '0;
            end else if (cnt_q == '1) begin
                deb_q <= sync2_q[b];
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + DEBOUNCE_W'(1);
            end
        end

        assign deb[b] = deb_q;
    end
`else
    assign deb = sync2_q;
`endif

    assign press = deb & ~deb_prev_q;

    for (genvar p = 0; p < PLAYERS; p++) begin : g_player
        // Even players start heading right, odd players heading left
        localparam logic [1:0] RST_DIR = (p % 2 == 0) ? 2'b11 : 2'b10;

        logic [1:0]       mem_q [QUEUE_DEPTH];
        logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
        logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
        logic [CNT_W-1:0] count_q, count_d;
        logic [1:0]       dir_q, dir_d;
        logic             pressed_q, pressed_d;
        logic             ovf_q, ovf_d;

        logic [3:0]       pvec;
        logic [PTR_W-1:0] tail_ptr;
        logic [1:0]       press_dir;
        logic [1:0]       ref_dir;
        logic             press_vld;
        logic             empty;
        logic             full;
        logic             legal;
        logic             do_pop;
        logic             do_push;

        assign pvec = press[4*p +: 4];

        // Press arbitration, legality check and queue next-state
        always_comb begin
            press_vld = |pvec;
            press_dir = 2'b00;
            if (pvec[0]) begin
                press_dir = 2'b00;
            end else if (pvec[1]) begin
                press_dir = 2'b01;
            end else if (pvec[2]) begin
                press_dir = 2'b10;
            end else if (pvec[3]) begin
                press_dir = 2'b11;
            end

            empty    = (count_q == '0);
            full     = (count_q == CNT_W'(QUEUE_DEPTH));
            tail_ptr = (wr_ptr_q == '0) ? PTR_W'(QUEUE_DEPTH - 1) : wr_ptr_q - PTR_W'(1);
            // Newest queued turn is the reference even if it is popped this cycle
            ref_dir  = empty ? dir_q : mem_q[tail_ptr];

            // Same axis means repeat or reversal; only a perpendicular turn is legal
            legal   = press_vld && (press_dir[1] != ref_dir[1]);
            do_pop  = i_tick && !empty;
            do_push = legal && (!full || do_pop);

            dir_d     = dir_q;
            rd_ptr_d  = rd_ptr_q;
            wr_ptr_d  = wr_ptr_q;
            count_d   = count_q;
            pressed_d = do_push;
            ovf_d     = legal && !do_push;

            if (do_pop) begin
                dir_d    = mem_q[rd_ptr_q];
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            if (do_push) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (do_push && !do_pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (do_pop && !do_push) begin
                count_d = count_q - CNT_W'(1);
            end

            // Restart overrides tick and push in the same cycle
            if (i_restart) begin
                dir_d     = RST_DIR;
                rd_ptr_d  = '0;
                wr_ptr_d  = '0;
                count_d   = '0;
                pressed_d = 1'b0;
                ovf_d     = 1'b0;
            end
        end

        // Queue and direction state
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                dir_q     <= RST_DIR;
                rd_ptr_q  <= '0;
                wr_ptr_q  <= '0;
                count_q   <= '0;
                pressed_q <= 1'b0;
                ovf_q     <= 1'b0;
                for (int i = 0; i < int'(QUEUE_DEPTH); i++) begin
                    mem_q[i] <= 2'b00;
                end
            end else begin
                dir_q     <= dir_d;
                rd_ptr_q  <= rd_ptr_d;
                wr_ptr_q  <= wr_ptr_d;
                count_q   <= count_d;
                pressed_q <= pressed_d;
                ovf_q     <= ovf_d;
                if (do_push && !i_restart) begin
                    mem_q[wr_ptr_q] <= press_dir;
                end
            end
        end

        assign o_dir[2*p +: 2] = dir_q;
        assign o_pressed[p]    = pressed_q;
        assign o_overflow[p]   = ovf_q;
    end

endmodule

// File: tb/tb_snake_dir_input.sv
// Directed bench for snake_dir_input with two players and a two-entry queue.
module tb_snake_dir_input;

    localparam int unsigned PLAYERS     = 2;
    localparam int unsigned DEBOUNCE_W  = 2;
    localparam int unsigned QUEUE_DEPTH = 2;
`ifdef SNAKE_DEBOUNCE_EN
    localparam int PLAT = 2 + (1 << DEBOUNCE_W);
`else
    localparam int PLAT = 2;
`endif

    localparam logic [7:0] B0_UP    = 8'h01;
    localparam logic [7:0] B0_DOWN  = 8'h02;
    localparam logic [7:0] B0_LEFT  = 8'h04;
    localparam logic [7:0] B0_RIGHT = 8'h08;
    localparam logic [3:0] DIR_RST  = 4'b1011;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] i_btn;
    logic       i_tick;
    logic       i_restart;
    logic [3:0] o_dir;
    logic [1:0] o_pressed;
    logic [1:0] o_overflow;

    int errors = 0;
    int checks = 0;

    snake_dir_input #(
        .PLAYERS     (PLAYERS),
        .DEBOUNCE_W  (DEBOUNCE_W),
        .QUEUE_DEPTH (QUEUE_DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_btn      (i_btn),
        .i_tick     (i_tick),
        .i_restart  (i_restart),
        .o_dir      (o_dir),
        .o_pressed  (o_pressed),
        .o_overflow (o_overflow)
    );

    always #5 clk = ~clk;

    // Hold buttons until the press cycle, optionally tick/restart in it, check pulses, release
    task automatic do_press(input logic [7:0] mask, input logic tick, input logic rst,
                            input logic [1:0] exp_p, input logic [1:0] exp_o, input string name);
        i_btn = mask;
        repeat (PLAT) @(negedge clk);
        i_tick    = tick;
        i_restart = rst;
        @(negedge clk);
        i_tick    = 1'b0;
        i_restart = 1'b0;
        checks++;
        if (o_pressed !== exp_p || o_overflow !== exp_o) begin
            errors++;
            $display("FAIL %s: pressed=%b overflow=%b, expected pressed=%b overflow=%b",
                     name, o_pressed, o_overflow, exp_p, exp_o);
        end
        @(negedge clk);
        checks++;
        if (o_pressed !== 2'b00 || o_overflow !== 2'b00) begin
            errors++;
            $display("FAIL %s_pulse_len: pressed=%b overflow=%b, expected 00 00",
                     name, o_pressed, o_overflow);
        end
        i_btn = '0;
        repeat (PLAT + 3) @(negedge clk);
    endtask

    task automatic do_tick(input logic [3:0] exp_dir, input string name);
        i_tick = 1'b1;
        @(negedge clk);
        i_tick = 1'b0;
        checks++;
        if (o_dir !== exp_dir) begin
            errors++;
            $display("FAIL %s: dir=%b, expected %b", name, o_dir, exp_dir);
        end
    endtask

    task automatic do_restart();
        i_restart = 1'b1;
        @(negedge clk);
        i_restart = 1'b0;
        checks++;
        if (o_dir !== DIR_RST) begin
            errors++;
            $display("FAIL restart_dir: dir=%b, expected %b", o_dir, DIR_RST);
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        i_btn     = '0;
        i_tick    = 1'b0;
        i_restart = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (o_dir !== DIR_RST || o_pressed !== 2'b00 || o_overflow !== 2'b00) begin
            errors++;
            $display("FAIL reset_state: dir=%b pressed=%b overflow=%b, expected %b 00 00",
                     o_dir, o_pressed, o_overflow, DIR_RST);
        end
        do_tick(DIR_RST, "reset_idle_tick");
    endtask

`ifdef SNAKE_DEBOUNCE_EN
    // Pin high for `hold` cycles, then count o_pressed[0] pulses
    task automatic glitch(input int hold, input int exp_cnt, input string name);
        int cnt;
        cnt   = 0;
        i_btn = B0_UP;
        repeat (hold) @(negedge clk);
        i_btn = '0;
        repeat (16) begin
            @(negedge clk);
            if (o_pressed[0] === 1'b1) cnt++;
        end
        checks++;
        if (cnt != exp_cnt) begin
            errors++;
            $display("FAIL %s: pulses=%0d, expected %0d", name, cnt, exp_cnt);
        end
    endtask
`endif

    task automatic test_debounce();
        do_restart();
`ifdef SNAKE_DEBOUNCE_EN
        glitch(3, 0, "debounce_short");
        glitch(4, 1, "debounce_exact");
`else
        do_press(B0_UP, 1'b0, 1'b0, 2'b01, 2'b00, "press_up");
`endif
        do_tick(4'b1000, "debounce_tick_up");
    endtask

    task automatic test_illegal();
        do_restart();
        do_press(B0_LEFT,  1'b0, 1'b0, 2'b00, 2'b00, "reverse_ignored");
        do_press(B0_RIGHT, 1'b0, 1'b0, 2'b00, 2'b00, "repeat_ignored");
        do_tick(DIR_RST, "illegal_queue_empty");
    endtask

    task automatic test_overflow();
        do_restart();
        do_press(B0_UP,   1'b0, 1'b0, 2'b01, 2'b00, "ovf_push_up");
        do_press(B0_LEFT, 1'b0, 1'b0, 2'b01, 2'b00, "ovf_push_left");
        do_press(B0_DOWN, 1'b0, 1'b0, 2'b00, 2'b01, "ovf_drop_down");
        do_tick(4'b1000, "ovf_tick1");
        do_tick(4'b1010, "ovf_tick2");
        do_tick(4'b1010, "ovf_tick3");
    endtask

    task automatic test_full_tick();
        do_restart();
        do_press(B0_UP,   1'b0, 1'b0, 2'b01, 2'b00, "full_push_up");
        do_press(B0_LEFT, 1'b0, 1'b0, 2'b01, 2'b00, "full_push_left");
        do_press(B0_DOWN, 1'b1, 1'b0, 2'b01, 2'b00, "full_push_with_tick");
        checks++;
        if (o_dir !== 4'b1000) begin
            errors++;
            $display("FAIL full_tick_pop: dir=%b, expected 1000", o_dir);
        end
        do_tick(4'b1010, "full_tick_left");
        do_tick(4'b1001, "full_tick_down");
        do_tick(4'b1001, "full_tick_empty");
    endtask

    task automatic test_priority();
        do_restart();
        // p0 up+down (up wins), p1 down+right (down wins)
        do_press(8'b1010_0011, 1'b0, 1'b0, 2'b11, 2'b00, "priority_press");
        do_tick(4'b0100, "priority_tick1");
        do_tick(4'b0100, "priority_tick2");
    endtask

    task automatic test_restart();
        do_restart();
        do_press(B0_UP,   1'b0, 1'b0, 2'b01, 2'b00, "restart_push_up");
        do_press(B0_LEFT, 1'b1, 1'b1, 2'b00, 2'b00, "restart_beats_push");
        checks++;
        if (o_dir !== DIR_RST) begin
            errors++;
            $display("FAIL restart_reload: dir=%b, expected %b", o_dir, DIR_RST);
        end
        do_tick(DIR_RST, "restart_queue_empty");
    endtask

    task automatic test_reset_mid();
        do_restart();
        do_press(B0_UP, 1'b0, 1'b0, 2'b01, 2'b00, "midreset_push");
        do_tick(4'b1000, "midreset_pop");
        do_press(B0_RIGHT, 1'b0, 1'b0, 2'b01, 2'b00, "midreset_push_right");
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (o_dir !== DIR_RST || o_pressed !== 2'b00) begin
            errors++;
            $display("FAIL async_reset: dir=%b pressed=%b, expected %b 00", o_dir, o_pressed, DIR_RST);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_tick(DIR_RST, "midreset_queue_empty");
    endtask

    initial begin
        test_reset();
        test_debounce();
        test_illegal();
        test_overflow();
        test_full_tick();
        test_priority();
        test_restart();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
